// File: rtl/acam_pkg.sv
// Shared definitions for the result-frame transmitter: FSM state encoding and
// the default frame sync byte.
package acam_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SYNC = 3'd1,
    SEQ  = 3'd2,
    DATA = 3'd3,
    CHK  = 3'd4
  } tx_state_t;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

endpackage

// File: rtl/frame_chk8.sv
// Mod-256 running sum of the bytes of one frame; cleared at frame start and
// advanced once per accepted byte.
module frame_chk8 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       add_en,
  input  logic [7:0] din,
  output logic [7:0] sum
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum <= '0;
    end else if (clr) begin
      sum <= '0;
    end else if (add_en) begin
      sum <= sum + din;
    end
  end

endmodule

// File: rtl/pos_frame_tx.sv
// Serialises a captured set of result words into a byte frame
// (sync, seq, data bytes, optional checksum) over a valid/ready byte handshake.
module pos_frame_tx
  import acam_pkg::*;
#(
  parameter int         NUM_WORDS = 2,
  parameter int         WORD_W    = 32,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT,
  parameter int         CHK_EN    = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        ena,
  input  logic [NUM_WORDS*WORD_W-1:0] data_in,
  output logic [7:0]                  byte_data,
  output logic                        byte_valid,
  input  logic                        byte_ready,
  output logic                        busy,
  output logic                        frame_done,
  output logic [7:0]                  drop_cnt
);

  localparam int BPW   = WORD_W / 8;
  localparam int NB    = NUM_WORDS * BPW;
  localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB - 1);

  tx_state_t                   state;
  logic [NUM_WORDS*WORD_W-1:0] shadow;
  logic [7:0]                  seq;
  logic [IDX_W-1:0]            byte_idx;
  logic [IDX_W-1:0]            next_idx;
  logic [7:0]                  stream [NB];
  logic                        xfer;
  logic                        accept;
  logic                        chk_add;
  logic [7:0]                  chk_sum;

  assign xfer     = byte_valid & byte_ready;
  assign accept   = ena & (state == IDLE);
  assign busy     = (state != IDLE);
  assign next_idx = byte_idx + IDX_W'(1);
  assign chk_add  = xfer & ((state == SEQ) | (state == DATA));

  // Wire order of data bytes: word 0 first, each word most-significant byte first.
  always_comb begin
    for (int k = 0; k < NB; k++) begin
      stream[k] = shadow[(k / BPW) * WORD_W + (BPW - 1 - (k % BPW)) * 8 +: 8];
    end
  end

  frame_chk8 u_chk (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (accept),
    .add_en (chk_add),
    .din    (byte_data),
    .sum    (chk_sum)
  );

  // Main frame sequencer; byte_data/byte_valid only change on a transfer, so
  // they hold steady through any number of stall cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      byte_data  <= '0;
      byte_valid <= 1'b0;
      frame_done <= 1'b0;
      seq        <= '0;
      byte_idx   <= '0;
      shadow     <= '0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (ena) begin
            shadow     <= data_in;
            byte_data  <= SYNC_BYTE;
            byte_valid <= 1'b1;
            state      <= SYNC;
          end
        end
        SYNC: begin
          if (xfer) begin
            byte_data <= seq;
            state     <= SEQ;
          end
        end
        SEQ: begin
          if (xfer) begin
            byte_idx  <= '0;
            byte_data <= stream[0];
            state     <= DATA;
          end
        end
        DATA: begin
          if (xfer) begin
            if (byte_idx == LAST_IDX) begin
              if (CHK_EN != 0) begin
                // The accumulator absorbs this byte on the same edge, so fold it in here.
                byte_data <= chk_sum + byte_data;
                state     <= CHK;
              end else begin
                byte_data  <= '0;
                byte_valid <= 1'b0;
                frame_done <= 1'b1;
                seq        <= seq + 8'd1;
                state      <= IDLE;
              end
            end else begin
              byte_idx  <= next_idx;
              byte_data <= stream[next_idx];
            end
          end
        end
        CHK: begin
          if (xfer) begin
            byte_data  <= '0;
            byte_valid <= 1'b0;
            frame_done <= 1'b1;
            seq        <= seq + 8'd1;
            state      <= IDLE;
          end
        end
        default: begin
          byte_valid <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

  // Requests arriving while a frame is in flight are dropped and tallied.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (ena && busy && (drop_cnt != 8'hFF)) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_pos_frame_tx.sv
// Directed bench for pos_frame_tx: default build plus a 3x16-bit, no-checksum build.
module tb_pos_frame_tx;

  logic        clk;
  logic        rst_n;

  logic        ena_a;
  logic [63:0] data_a;
  logic [7:0]  bd_a;
  logic        bv_a;
  logic        rdy_a;
  logic        busy_a;
  logic        fd_a;
  logic [7:0]  drop_a;

  logic        ena_b;
  logic [47:0] data_b;
  logic [7:0]  bd_b;
  logic        bv_b;
  logic        rdy_b;
  logic        busy_b;
  logic        fd_b;
  logic [7:0]  drop_b;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_f [11];
  logic [7:0] exp_b [8];

  pos_frame_tx dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena_a),
    .data_in    (data_a),
    .byte_data  (bd_a),
    .byte_valid (bv_a),
    .byte_ready (rdy_a),
    .busy       (busy_a),
    .frame_done (fd_a),
    .drop_cnt   (drop_a)
  );

  pos_frame_tx #(.NUM_WORDS(3), .WORD_W(16), .CHK_EN(0)) dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena_b),
    .data_in    (data_b),
    .byte_data  (bd_b),
    .byte_valid (bv_b),
    .byte_ready (rdy_b),
    .busy       (busy_b),
    .frame_done (fd_b),
    .drop_cnt   (drop_b)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference frame for the default build: sync, seq, word bytes MSB first, sum.
  task automatic set_model(input logic [63:0] d, input logic [7:0] s);
    logic [7:0] sum;
    sum = s;
    exp_f[0] = 8'hA5;
    exp_f[1] = s;
    for (int w = 0; w < 2; w++) begin
      for (int b = 0; b < 4; b++) begin
        exp_f[2 + w * 4 + b] = d[w * 32 + (3 - b) * 8 +: 8];
        sum = sum + d[w * 32 + (3 - b) * 8 +: 8];
      end
    end
    exp_f[10] = sum;
  endtask

  // mode 0: always ready; 1: ready pattern 1,0,0,1; 2: ready once every 30 cycles.
  task automatic send_frame_a(input logic [63:0] d, input int mode, input logic drops);
    int idx;
    int cyc;
    logic stalled;
    logic [7:0] held;
    idx = 0;
    cyc = 0;
    stalled = 1'b0;
    held = 8'h00;
    data_a = d;
    ena_a = 1'b1;
    rdy_a = 1'b0;
    step();
    ena_a = 1'b0;
    chk("first_valid", 32'(bv_a), 32'd1);
    while (idx < 11 && cyc < 2000) begin
      if (mode == 0)      rdy_a = 1'b1;
      else if (mode == 1) rdy_a = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      else                rdy_a = ((cyc % 30) == 29);
      if (stalled) chk("stall_hold", 32'({bv_a, bd_a}), 32'({1'b1, held}));
      ena_a = drops;
      data_a = {$urandom, $urandom};
      if (bv_a && rdy_a) begin
        chk($sformatf("byte%0d", idx), 32'(bd_a), 32'(exp_f[idx]));
        idx++;
        stalled = 1'b0;
      end else begin
        chk("valid_in_frame", 32'(bv_a), 32'd1);
        stalled = 1'b1;
        held = bd_a;
      end
      step();
      cyc++;
    end
    ena_a = 1'b0;
    rdy_a = 1'b1;
    chk("frame_no_timeout", 32'(cyc < 2000), 32'd1);
    if (mode == 0) chk("frame_cycles", 32'(cyc), 32'd11);
    chk("done_pulse", 32'(fd_a), 32'd1);
    chk("idle_busy", 32'(busy_a), 32'd0);
    chk("idle_valid", 32'(bv_a), 32'd0);
    step();
    chk("done_single", 32'(fd_a), 32'd0);
  endtask

  initial begin
    clk = 1'b0;
    rst_n = 1'b0;
    ena_a = 1'b0;
    data_a = '0;
    rdy_a = 1'b1;
    ena_b = 1'b0;
    data_b = '0;
    rdy_b = 1'b1;

    #12;
    chk("rst_valid", 32'(bv_a), 32'd0);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_done", 32'(fd_a), 32'd0);
    chk("rst_data", 32'(bd_a), 32'd0);
    chk("rst_drop", 32'(drop_a), 32'd0);
    chk("rst_b_valid", 32'(bv_b), 32'd0);
    #1;
    rst_n = 1'b1;
    step();

    // Hand-computed default frame, ready tied high.
    exp_f = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h00, 8'h00, 8'h03, 8'h04, 8'h0A};
    send_frame_a({32'h00000304, 32'h00000102}, 0, 1'b0);

    // Same payload under a stalling receiver.
    exp_f = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h01, 8'h02, 8'h00, 8'h00, 8'h03, 8'h04, 8'h0B};
    send_frame_a({32'h00000304, 32'h00000102}, 1, 1'b0);
    chk("drop_zero", 32'(drop_a), 32'd0);

    // Flood of requests during a long frame.
    set_model(64'hDEADBEEF_CAFEF00D, 8'h02);
    send_frame_a(64'hDEADBEEF_CAFEF00D, 2, 1'b1);
    chk("drop_sat", 32'(drop_a), 32'd255);

    // Reset while DATA byte 3 is on the bus.
    data_a = 64'h11223344_55667788;
    ena_a = 1'b1;
    rdy_a = 1'b1;
    step();
    ena_a = 1'b0;
    repeat (5) step();
    chk("abort_byte3", 32'(bd_a), 32'h88);
    chk("abort_busy_pre", 32'(busy_a), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_valid", 32'(bv_a), 32'd0);
    chk("abort_busy", 32'(busy_a), 32'd0);
    chk("abort_drop", 32'(drop_a), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      step();
      chk("abort_no_done", 32'(fd_a), 32'd0);
    end

    // 258 back-to-back frames from reset: seq walks 00..FF, then 00, 01.
    for (int f = 0; f < 258; f++) begin
      logic [63:0] d;
      d = {$urandom, $urandom};
      set_model(d, f[7:0]);
      send_frame_a(d, 0, 1'b0);
    end

    // Narrow build without checksum; restart in the frame_done cycle.
    exp_b = '{8'hA5, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    data_b = {16'h0506, 16'h0304, 16'h0102};
    ena_b = 1'b1;
    step();
    ena_b = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("b_valid%0d", i), 32'(bv_b), 32'd1);
      chk($sformatf("b_byte%0d", i), 32'(bd_b), 32'(exp_b[i]));
      step();
    end
    chk("b_done", 32'(fd_b), 32'd1);
    chk("b_idle", 32'(busy_b), 32'd0);
    data_b = {16'hA1A2, 16'hB1B2, 16'hC1C2};
    ena_b = 1'b1;
    step();
    ena_b = 1'b0;
    chk("b_restart_busy", 32'(busy_b), 32'd1);
    chk("b_restart_done_low", 32'(fd_b), 32'd0);
    exp_b = '{8'hA5, 8'h01, 8'hC1, 8'hC2, 8'hB1, 8'hB2, 8'hA1, 8'hA2};
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("b2_byte%0d", i), 32'({bv_b, bd_b}), 32'({1'b1, exp_b[i]}));
      step();
    end
    chk("b2_done", 32'(fd_b), 32'd1);
    chk("b_drop", 32'(drop_b), 32'd0);
    step();
    chk("b2_done_single", 32'(fd_b), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
